// File: rtl/openram_demo_pkg.sv
`default_nettype none
// openram_demo_pkg: shared types and constants for the OpenRAM demo wrapper.
// Rev 1.0
package openram_demo_pkg;

  localparam int SRAM_DW = 32;
  localparam int SRAM_AW = 8;
  localparam int SRAM_WM = 4;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_FC00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

endpackage : openram_demo_pkg
`default_nettype wire

// File: rtl/wb_sram_bridge.sv
`default_nettype none
// wb_sram_bridge: Wishbone classic slave driving port 0 of the OpenRAM 32x256 1RW macro.
// Rev 1.0
module wb_sram_bridge
  import openram_demo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter int          AW        = SRAM_AW,
  parameter int          RD_LAT    = 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [SRAM_WM-1:0] wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [SRAM_DW-1:0] wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [SRAM_DW-1:0] wbs_dat_o,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [SRAM_WM-1:0] sram_wmask0,
  output logic [AW-1:0]      sram_addr0,
  output logic [SRAM_DW-1:0] sram_din0,
  input  logic [SRAM_DW-1:0] sram_dout0,
  output logic               busy_o,
  output logic [15:0]        acc_cnt_o
);

  state_e             state_q, state_d;
  logic               csb_q, csb_d;
  logic               web_q, web_d;
  logic [SRAM_WM-1:0] wmask_q, wmask_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [SRAM_DW-1:0] din_q, din_d;
  logic               ack_q, ack_d;
  logic [SRAM_DW-1:0] dat_q, dat_d;
  logic [1:0]         lat_q, lat_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               hit;

  assign hit = ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      lat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

  // csb_d defaults high so the chip select is low only in the single CMD cycle.
  always_comb begin
    state_d = state_q;
    csb_d   = 1'b1;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && hit) begin
          addr_d  = wbs_adr_i[AW+1:2];
          din_d   = wbs_dat_i;
          wmask_d = wbs_we_i ? wbs_sel_i : '0;
          web_d   = ~wbs_we_i;
          csb_d   = 1'b0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!web_q) begin
          if (wbs_cyc_i) begin
            ack_d   = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          lat_d   = 2'(RD_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == 2'd0) begin
          if (wbs_cyc_i) begin
            dat_d   = sram_dout0;
            ack_d   = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign acc_cnt_o   = cnt_q;

endmodule : wb_sram_bridge
`default_nettype wire
